// File: rtl/gf163_reduce_seq.sv
// ---------------------------------------------------------------------------
// gf163_reduce_seq
//   Multi-cycle reducer for GF(2^163) products. It takes the unreduced
//   325-bit product (degree <= 324) from the multiplier tree and reduces it
//   modulo f(x) = x^163 + x^7 + x^6 + x^3 + 1. Each cycle folds one window of
//   at most FOLD high-order bits, working from the top down.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   unreduced product present on in_c
//   in_ready   block can accept an operand (IDLE)
//   in_c       unreduced product, bit i = coefficient of x^i
//   out_valid  out_r holds a reduced result (DONE)
//   out_ready  consumer accepts out_r
//   out_r      reduced result, bit i = coefficient of x^i
//   busy       high in FOLD or DONE
// ---------------------------------------------------------------------------
module gf163_reduce_seq #(
    parameter int FOLD = 41            // legal range 1..156
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [324:0] in_c,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [162:0] out_r,
    output logic         busy
);

    localparam int NCYC  = (162 + FOLD - 1) / FOLD;
    localparam int CNT_W = $clog2(NCYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FOLD,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [324:0]       w_q;       // working polynomial
    logic [324:0]       w_fold;    // working polynomial after this cycle's window
    logic [8:0]         t_q;       // window top (exclusive)
    logic [8:0]         l_ptr;     // window bottom (inclusive)
    logic [CNT_W-1:0]   cnt_q;
    logic [162:0]       r_q;
    logic               last_fold;

    assign last_fold = (state_q == S_FOLD) && (cnt_q == CNT_W'(NCYC - 1));

    // Window bottom: L = max(T - FOLD, 163).
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        l_ptr = 9'd163;
        if (t_q > 9'(163 + FOLD))
            l_ptr = t_q - 9'(FOLD);
    end

    // x^p = x^(p-156) + x^(p-157) + x^(p-160) + x^(p-163) mod f(x).
    // All targets land below L (FOLD <= 156), so bits inside one window never
    // feed each other and the whole window folds in parallel.
    always_comb begin
        w_fold = w_q;
        for (int p = 163; p < 325; p++) begin
            if (w_q[p] && (p >= int'(l_ptr)) && (p < int'(t_q))) begin
                w_fold[p]       = 1'b0;
                w_fold[p - 163] = w_fold[p - 163] ^ 1'b1;
                w_fold[p - 160] = w_fold[p - 160] ^ 1'b1;
                w_fold[p - 157] = w_fold[p - 157] ^ 1'b1;
                w_fold[p - 156] = w_fold[p - 156] ^ 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register updates from the values present before the edge.
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid)  state_d = S_FOLD;
            S_FOLD: if (last_fold) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the working register is reset as well, so a discarded
        // operand never leaks into observable state after reset.
        if (!rst_n) begin
            w_q   <= '0;
            t_q   <= 9'd325;
            cnt_q <= '0;
            r_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        w_q   <= in_c;
                        t_q   <= 9'd325;
                        cnt_q <= '0;
                    end
                end
                S_FOLD: begin
                    w_q   <= w_fold;
                    t_q   <= l_ptr;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_fold)
                        r_q <= w_fold[162:0];
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_r     = r_q;

endmodule

// File: doc/gf163_reduce_seq.md
Name: gf163_reduce_seq

Overview:
- Multi-cycle modular reducer for the GF(2^163) datapath.
- Consumes the unreduced 325-bit polynomial product from the Karatsuba multiplier tree (163x163 -> degree <= 324).
- Reduces it modulo f(x) = x^163 + x^7 + x^6 + x^3 + 1 and returns the 163-bit field element.
- Sits between the multiplier and the point-arithmetic register file; valid/ready handshake on both sides.

Parameters:
- FOLD, 41, number of high-order bits folded per cycle; legal range 1..156.
- NCYC, ceil(162/FOLD) (derived localparam, not overridable), fold cycles per operation; 4 at default.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  unreduced product present on in_c.
- in_ready  output  1  block can accept an operand.
- in_c  input  325  unreduced product, bit i = coefficient of x^i.
- out_valid  output  1  out_r holds a reduced result.
- out_ready  input  1  consumer accepts out_r.
- out_r  output  163  reduced result, bit i = coefficient of x^i.
- busy  output  1  high in FOLD or DONE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0, busy=0, out_r=0.
  - Working register W[324:0]=0 and window pointer T=325.
  - Applies immediately, including mid-operation; any in-flight operand is discarded.
- States: IDLE, FOLD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a clock edge: W<=in_c, T<=325, counter<=0, go to FOLD.
- FOLD (one window per cycle, top down):
  - Window = W[T-1:L], where L = max(T-FOLD, 163).
  - For each set bit p in the window, clear it and XOR 1 into bit positions p-163, p-160, p-157, p-156.
  - Then T<=L and counter<=counter+1.
  - Since FOLD<=156, every target bit lies strictly below L. Bits in 163..L-1 are folded by a later window.
  - When L==163 (counter reaches NCYC-1), the window is processed and the state goes to DONE.
  - out_r<=W[162:0] after that fold, and out_valid<=1 on the same edge.
  - Bits 324..163 are zero after the final fold.
- Last window: may be narrower than FOLD. With FOLD=41 the windows are [324:284], [283:243], [242:202], [201:163].
- DONE:
  - out_valid=1; out_r stable until out_ready=1 at a clock edge.
  - On that edge: out_valid<=0, go to IDLE.
  - in_ready=0 throughout DONE. No accept in the same cycle as the output handshake.
- Latency: operand accepted at edge k -> out_valid high after edge k+NCYC (4 at default).
  - Throughput: one result per NCYC+2 cycles with out_ready held high.
- in_c is sampled only on the accept edge; later changes are ignored.
  - in_valid outside IDLE is ignored and causes no accept.
- out_r keeps the last result after the handshake; consumers qualify it with out_valid.
- Arithmetic: pure GF(2), XOR only, no carries.
  - Input bits 162..0 pass through unchanged when bits 324..163 are zero.

Test Plan:
- Zero: in_c=0 -> out_valid rises exactly 4 cycles after accept, out_r=0.
- Single fold: in_c=1<<163 -> out_r=163'hC9 (x^7+x^6+x^3+1).
- Pass-through: in_c=163'h5 with upper bits 0 -> out_r=163'h5.
- Chained fold: in_c=1<<324 -> out_r = (1<<161) | 163'h1422 (x^161+x^12+x^10+x^5+x).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - out_r and out_valid stay stable, in_ready=0, a second in_valid is not accepted.
  - Raise out_ready -> IDLE next cycle, then the second operand is accepted.
- Reset mid-FOLD and sweep:
  - Assert rst_n=0 on the second FOLD cycle -> out_valid=0 and in_ready=1 immediately; the next operand reduces correctly.
  - 1000 random products checked against a software reducer, at FOLD=41 and FOLD=1 (NCYC=162).
